// File: rtl/lb_window_ctrl_pkg.sv
// Shared definitions for the line-buffer window sequencer: FSM states, buffer geometry
// and the modulo-3 rotation helper.
package lb_window_ctrl_pkg;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned LB_NUM    = 3;
    localparam int unsigned LB_RD_LAT = 2;
    localparam int unsigned LB_RD_W   = 3 * PIX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SCAN_REQ,
        ST_SCAN_W1,
        ST_SCAN_CAP,
        ST_SCAN_OUT
    } state_t;

    function automatic logic [1:0] mod3_inc(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

endpackage

// File: rtl/lb_window_ctrl_rotator.sv
// lb_row_rotator: reorders the three line-buffer read words so that the buffer holding the
// oldest row lands in the low slice and the newest row in the high slice.
module lb_row_rotator
    import lb_window_ctrl_pkg::*;
(
    input  logic [1:0]                i_top,
    input  logic [LB_NUM*LB_RD_W-1:0] i_rd_data,
    output logic [LB_NUM*LB_RD_W-1:0] o_win
);

    logic [LB_RD_W-1:0] w_lb0;
    logic [LB_RD_W-1:0] w_lb1;
    logic [LB_RD_W-1:0] w_lb2;

    assign w_lb0 = i_rd_data[0*LB_RD_W +: LB_RD_W];
    assign w_lb1 = i_rd_data[1*LB_RD_W +: LB_RD_W];
    assign w_lb2 = i_rd_data[2*LB_RD_W +: LB_RD_W];

    always_comb begin
        o_win = {w_lb2, w_lb1, w_lb0};
        case (i_top)
            2'd1:    o_win = {w_lb0, w_lb2, w_lb1};
            2'd2:    o_win = {w_lb1, w_lb0, w_lb2};
            default: o_win = {w_lb2, w_lb1, w_lb0};
        endcase
    end

endmodule

// File: rtl/lb_window_ctrl.sv
// lb_window_ctrl: loads image rows into three rotating line buffers and scans each 3-row
// band column by column, emitting 3x3 windows on a valid/ready port.
module lb_window_ctrl
    import lb_window_ctrl_pkg::*;
#(
    parameter int unsigned ROW_W = 100,
    parameter int unsigned IMG_H = 100
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      s_valid,
    input  logic [31:0]               s_data,
    output logic                      s_ready,
    output logic [LB_NUM-1:0]         lb_wr_en,
    output logic [31:0]               lb_wr_data,
    output logic [LB_NUM-1:0]         lb_rd_en,
    output logic [6:0]                lb_rd_addr,
    input  logic [LB_NUM*LB_RD_W-1:0] lb_rd_data,
    output logic                      win_valid,
    input  logic                      win_ready,
    output logic [LB_NUM*LB_RD_W-1:0] win_data,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int unsigned WORDS     = ROW_W / 4;
    localparam logic [4:0]  LAST_WORD = 5'(WORDS - 1);
    localparam logic [6:0]  LAST_COL  = 7'(ROW_W - 3);
    localparam logic [6:0]  ROWS_ALL  = 7'(IMG_H);
    localparam logic [1:0]  W1_LAST   = 2'(LB_RD_LAT - 2);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [6:0]                r_col;
    logic [4:0]                r_word_cnt;
    logic [6:0]                r_rows_in;
    logic [1:0]                r_top;
    logic [1:0]                r_wait;
    logic                      r_rdy_phase;
    logic                      r_win_valid;
    logic [LB_NUM*LB_RD_W-1:0] r_win_data;
    logic                      r_frame_done;

    logic                      w_fill;
    logic                      w_accept;
    logic                      w_row_done;
    logic                      w_wait_done;
    logic [1:0]                w_wsel;
    logic [LB_NUM*LB_RD_W-1:0] w_rot;

    assign w_fill      = (r_state == ST_FILL);
    assign w_accept    = s_ready && s_valid;
    assign w_row_done  = (r_word_cnt == LAST_WORD);
    assign w_wait_done = (r_wait == W1_LAST);
    // First three rows of a frame go to LB0..LB2; afterwards the oldest buffer is refilled.
    assign w_wsel      = (r_rows_in < 7'd3) ? r_rows_in[1:0] : r_top;

    assign s_ready    = w_fill && r_rdy_phase;
    assign lb_wr_en   = w_accept ? (3'b001 << w_wsel) : '0;
    assign lb_wr_data = w_fill ? s_data : '0;
    assign lb_rd_en   = (r_state == ST_SCAN_REQ) ? '1 : '0;
    assign lb_rd_addr = r_col;
    assign win_valid  = r_win_valid;
    assign win_data   = r_win_data;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_frame_done;

    lb_row_rotator u_rotator (
        .i_top     (r_top),
        .i_rd_data (lb_rd_data),
        .o_win     (w_rot)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_accept && w_row_done && (r_rows_in >= 7'd2)) begin
                    w_state_nxt = ST_SCAN_REQ;
                end
            end
            ST_SCAN_REQ: w_state_nxt = ST_SCAN_W1;
            ST_SCAN_W1: begin
                if (w_wait_done) begin
                    w_state_nxt = ST_SCAN_CAP;
                end
            end
            ST_SCAN_CAP: w_state_nxt = ST_SCAN_OUT;
            ST_SCAN_OUT: begin
                if (win_ready) begin
                    if (r_col < LAST_COL) begin
                        w_state_nxt = ST_SCAN_REQ;
                    end else if (r_rows_in == ROWS_ALL) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col        <= '0;
            r_word_cnt   <= '0;
            r_rows_in    <= '0;
            r_top        <= '0;
            r_wait       <= '0;
            r_rdy_phase  <= 1'b0;
            r_win_valid  <= 1'b0;
            r_win_data   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_col       <= '0;
                        r_word_cnt  <= '0;
                        r_rows_in   <= '0;
                        r_top       <= '0;
                        r_rdy_phase <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (w_accept) begin
                        r_rdy_phase <= 1'b0;
                        if (w_row_done) begin
                            r_word_cnt <= '0;
                            r_rows_in  <= r_rows_in + 7'd1;
                            r_col      <= '0;
                            if (r_rows_in >= 7'd3) begin
                                r_top <= mod3_inc(r_top);
                            end
                        end else begin
                            r_word_cnt <= r_word_cnt + 5'd1;
                        end
                    end else begin
                        r_rdy_phase <= 1'b1;
                    end
                end
                ST_SCAN_REQ: r_wait <= '0;
                ST_SCAN_W1: begin
                    if (!w_wait_done) begin
                        r_wait <= r_wait + 2'd1;
                    end
                end
                ST_SCAN_CAP: begin
                    r_win_data  <= w_rot;
                    r_win_valid <= 1'b1;
                end
                ST_SCAN_OUT: begin
                    if (win_ready) begin
                        r_win_valid <= 1'b0;
                        if (r_col < LAST_COL) begin
                            r_col <= r_col + 7'd1;
                        end else if (r_rows_in == ROWS_ALL) begin
                            r_frame_done <= 1'b1;
                        end else begin
                            r_rdy_phase <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lb_window_ctrl.sv
// Randomised bench for lb_window_ctrl: line buffers are modelled behaviourally and every
// window is compared against the image rows it should cover.
module tb_lb_window_ctrl;

    localparam int ROW_W = 8;
    localparam int IMG_H = 5;
    localparam int WORDS = ROW_W / 4;
    localparam int NCOL  = ROW_W - 2;
    localparam int NWIN  = (ROW_W - 2) * (IMG_H - 2);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        win_ready = 1'b0;
    logic [71:0] lb_rd_data = '0;
    logic        s_ready;
    logic [2:0]  lb_wr_en;
    logic [31:0] lb_wr_data;
    logic [2:0]  lb_rd_en;
    logic [6:0]  lb_rd_addr;
    logic        win_valid;
    logic [71:0] win_data;
    logic        busy;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lb_window_ctrl #(.ROW_W(ROW_W), .IMG_H(IMG_H)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .lb_wr_en   (lb_wr_en),
        .lb_wr_data (lb_wr_data),
        .lb_rd_en   (lb_rd_en),
        .lb_rd_addr (lb_rd_addr),
        .lb_rd_data (lb_rd_data),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'(r * 16 + c);
    endfunction

    function automatic logic [31:0] word_of(input int idx);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[k*8 +: 8] = pix(idx / WORDS, (idx % WORDS) * 4 + k);
        return w;
    endfunction

    // Window n covers rows band..band+2 (oldest low) and columns col..col+2 (lowest col low).
    function automatic logic [71:0] win_of(input int n);
        logic [71:0] x;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++)
                x[i*24 + k*8 +: 8] = pix(n / NCOL + i, n % NCOL + k);
        return x;
    endfunction

    logic [7:0]  lbmem [3][ROW_W];
    int          wptr [3];
    logic        pa_v, pb_v, pc_v;
    logic [6:0]  pa_a, pb_a, pc_a;
    int          acc_cnt, win_cnt, cyc, last_acc_cyc, last_win_cyc;
    logic        fd_exp, prev_hold, prev_acc;
    logic [71:0] prev_win;
    bit          ready_always, valid_always;

    function automatic logic [23:0] rd24(input int b, input int a);
        return {lbmem[b][a+2], lbmem[b][a+1], lbmem[b][a]};
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            for (int b = 0; b < 3; b++) begin
                wptr[b] = 0;
                for (int c = 0; c < ROW_W; c++) lbmem[b][c] = '0;
            end
            {pa_v, pb_v, pc_v} = '0;
            acc_cnt = 0; win_cnt = 0;
            fd_exp = 1'b0; prev_hold = 1'b0; prev_acc = 1'b0;
            lb_rd_data = '0;
        end else begin
            if (start && !busy) begin
                acc_cnt = 0;
                win_cnt = 0;
            end
            if (prev_acc) chk("rdy_after_acc", 72'(s_ready), 72'(0));
            prev_acc = s_valid && s_ready;
            if (s_valid && s_ready) begin
                chk("wr_en", 72'(lb_wr_en), 72'(3'b001 << ((acc_cnt / WORDS) % 3)));
                chk("wr_data", 72'(lb_wr_data), 72'(s_data));
                if (valid_always && (acc_cnt % WORDS != 0))
                    chk("fill_gap", 72'(cyc - last_acc_cyc), 72'(2));
                for (int b = 0; b < 3; b++) begin
                    if (lb_wr_en[b]) begin
                        for (int k = 0; k < 4; k++) lbmem[b][wptr[b]*4 + k] = lb_wr_data[k*8 +: 8];
                        wptr[b] = (wptr[b] + 1) % WORDS;
                    end
                end
                acc_cnt++;
                last_acc_cyc = cyc;
            end else begin
                chk("wr_idle", 72'(lb_wr_en), 72'(0));
            end

            chk("rd_en_shape", 72'(lb_rd_en == 3'b000 || lb_rd_en == 3'b111), 72'(1));
            chk("rd_wr_clash", 72'(lb_wr_en & lb_rd_en), 72'(0));
            if (win_valid) chk("rd_while_out", 72'(lb_rd_en), 72'(0));
            pc_v = pb_v; pc_a = pb_a;
            pb_v = pa_v; pb_a = pa_a;
            pa_v = (lb_rd_en == 3'b111); pa_a = lb_rd_addr;
            if (pc_v) lb_rd_data = {rd24(2, int'(pc_a)), rd24(1, int'(pc_a)), rd24(0, int'(pc_a))};
            else      lb_rd_data = {8'($urandom), 32'($urandom), 32'($urandom)};

            if (prev_hold) begin
                chk("hold_valid", 72'(win_valid), 72'(1));
                chk("hold_data", win_data, prev_win);
            end
            chk("frame_done", 72'(frame_done), 72'(fd_exp));
            if (frame_done) chk("done_idle", 72'(busy), 72'(0));
            fd_exp = 1'b0;
            if (win_valid && win_ready) begin
                chk("win_data", win_data, win_of(win_cnt));
                if (ready_always && (win_cnt % NCOL != 0))
                    chk("win_gap", 72'(cyc - last_win_cyc), 72'(4));
                last_win_cyc = cyc;
                win_cnt++;
                fd_exp = (win_cnt == NWIN);
            end
            prev_hold = win_valid && !win_ready;
            prev_win  = win_data;
            if (!busy) chk("idle_quiet", 72'({s_ready, lb_wr_en, lb_rd_en, win_valid}), 72'(0));
        end
    end

    int hold_cnt;
    bit held_once;

    task automatic drive_cycle(input bit rnd, input bit poke_start);
        @(posedge clk);
        #1;
        start  = poke_start;
        s_data = word_of(acc_cnt);
        if (rnd) begin
            s_valid = 1'($urandom_range(0, 1));
            if (hold_cnt > 0) begin
                win_ready = 1'b0;
                hold_cnt--;
            end else if (win_valid && !held_once) begin
                win_ready = 1'b0;
                hold_cnt  = 9;
                held_once = 1'b1;
            end else begin
                win_ready = ($urandom_range(0, 3) != 0);
            end
        end else begin
            s_valid   = 1'b1;
            win_ready = 1'b1;
        end
    endtask

    task automatic run_frame(input string name, input bit rnd, input int poke_at);
        bit seen = 1'b0;
        held_once = 1'b0;
        hold_cnt  = 0;
        drive_cycle(rnd, 1'b1);
        drive_cycle(rnd, 1'b0);
        chk({name, "_first_rdy"}, 72'(s_ready), 72'(1));
        chk({name, "_busy"}, 72'(busy), 72'(1));
        for (int i = 0; i < 1000 && !seen; i++) begin
            drive_cycle(rnd, i == poke_at);
            if (frame_done) seen = 1'b1;
        end
        chk({name, "_done_seen"}, 72'(seen), 72'(1));
        chk({name, "_busy_at_done"}, 72'(busy), 72'(0));
        chk({name, "_win_count"}, 72'(win_cnt), 72'(NWIN));
        for (int i = 0; i < 4; i++) begin
            drive_cycle(rnd, 1'b0);
            chk({name, "_stay_idle"}, 72'(busy), 72'(0));
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", 72'({s_ready, lb_wr_en, lb_rd_en, lb_rd_addr, win_valid, busy, frame_done}), 72'(0));
        chk("reset_wdata", 72'(lb_wr_data), 72'(0));
        chk("reset_win", win_data, 72'(0));
        @(negedge clk);
        rst = 1'b1;

        ready_always = 1'b1;
        valid_always = 1'b1;
        run_frame("f1", 1'b0, 20);

        ready_always = 1'b0;
        valid_always = 1'b0;
        run_frame("f2", 1'b1, -1);

        held_once = 1'b0;
        hold_cnt  = 0;
        drive_cycle(1'b1, 1'b1);
        for (int i = 0; i < 40; i++) drive_cycle(1'b1, 1'b0);
        chk("busy_before_rst", 72'(busy), 72'(1));
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_ctrl", 72'({s_ready, lb_wr_en, lb_rd_en, lb_rd_addr, win_valid, busy, frame_done}), 72'(0));
        chk("midrst_wdata", 72'(lb_wr_data), 72'(0));
        chk("midrst_win", win_data, 72'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_frame("f4", 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
